// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM state encoding, default limits and the datapath width.
package mem_port_arbiter_pkg;

  localparam int unsigned DATA_W               = 16;
  localparam int unsigned DEFAULT_STARVE_LIMIT = 3;
  localparam int unsigned DEFAULT_TIMEOUT      = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_timeout_counter.sv
// Down-counter that bounds how long a memory access may stay outstanding.
// Loaded with LIMIT-1 on acceptance, so expired rises in the LIMIT-th busy cycle.
module arb_timeout_counter #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(LIMIT - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-outstanding memory port.
// Data normally wins; a waiting fetch is forced through after STARVE_LIMIT data grants.
//
// state   | meaning
// IDLE    | no access outstanding, arbitration happens at the next edge
// IF_BUSY | fetch read in flight on the memory port
// D_BUSY  | data read or write in flight on the memory port
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int unsigned TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  localparam int unsigned SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_t        state_q, state_d;
  logic [SW-1:0]     starve_cnt;
  logic              starve_hit;
  logic              grant_if, grant_d;
  logic              ack_done, to_done;
  logic              expired;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic              we_q;

  assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    ack_done = 1'b0;
    to_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req && (!d_req || starve_hit)) begin
          grant_if = 1'b1;
          state_d  = IF_BUSY;
        end else if (d_req) begin
          grant_d = 1'b1;
          state_d = D_BUSY;
        end
      end
      IF_BUSY, D_BUSY: begin
        // An ack in the expiry cycle still counts as a normal completion.
        if (mem_ack) begin
          ack_done = 1'b1;
          state_d  = IDLE;
        end else if (expired) begin
          to_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  arb_timeout_counter #(.LIMIT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .load    (grant_if | grant_d),
    .en      (state_q != IDLE),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      if_gnt      <= 1'b0;
      d_gnt       <= 1'b0;
      if_valid    <= 1'b0;
      d_valid     <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      starve_cnt  <= '0;
      timeout_err <= 1'b0;
    end else begin
      if_gnt   <= grant_if;
      d_gnt    <= grant_d;
      if_valid <= (ack_done || to_done) && (state_q == IF_BUSY);
      d_valid  <= (ack_done || to_done) && (state_q == D_BUSY);

      if (grant_if) begin
        addr_q     <= if_addr;
        wdata_q    <= '0;
        we_q       <= 1'b0;
        starve_cnt <= '0;
      end
      if (grant_d) begin
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        we_q    <= d_we;
        if (if_req && !starve_hit) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end

      if (state_q == IF_BUSY) begin
        if (ack_done) begin
          if_rdata <= mem_rdata;
        end else if (to_done) begin
          if_rdata <= '0;
        end
      end
      // Write completions leave d_rdata untouched; a timed-out access reports zero.
      if (state_q == D_BUSY) begin
        if (ack_done && !we_q) begin
          d_rdata <= mem_rdata;
        end else if (to_done) begin
          d_rdata <= '0;
        end
      end

      if (to_done) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
